// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared definitions for the sram request arbiter.
//   - owner IDs stored in the in-order response FIFO
//   - request-side FSM state encoding
//   - access size encodings carried on the *_size buses
package sram_arb_pkg;

   localparam logic ID_INST = 1'b0;
   localparam logic ID_DATA = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOCK_I = 2'd1,
      ST_LOCK_D = 2'd2
   } arb_state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_id_fifo.sv
// sram_arb_id_fifo: in-order FIFO of 1-bit owner IDs, one per accepted
// transaction still waiting for its data_ok.
// Ports:
//   clk, resetn    clock, asynchronous active-low reset (empties the FIFO)
//   push, push_id  enqueue push_id (ignored when full)
//   pop            dequeue the head (ignored when empty)
//   head           owner ID at the head
//   full, empty    status from the registered pointers
module sram_arb_id_fifo
   import sram_arb_pkg::*;
#(
   parameter int OUTSTANDING = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  logic push_id,
   input  logic pop,
   output logic head,
   output logic full,
   output logic empty
);

   // Index bits plus one wrap bit. IS keeps index vectors legal at depth 1.
   localparam int IW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 0;
   localparam int IS = (IW > 0) ? IW : 1;

   logic [IW:0]             wr_ptr;
   logic [IW:0]             rd_ptr;
   logic [IW:0]             used;
   logic [IS-1:0]           wr_idx;
   logic [IS-1:0]           rd_idx;
   logic [OUTSTANDING-1:0]  mem;

   generate
      if (IW == 0) begin : g_single
         assign wr_idx = '0;
         assign rd_idx = '0;
      end else begin : g_multi
         assign wr_idx = wr_ptr[IS-1:0];
         assign rd_idx = rd_ptr[IS-1:0];
      end
   endgenerate

   // Equal index with differing wrap bit is exactly a pointer distance of
   // OUTSTANDING, which is how full is computed here.
   assign used  = wr_ptr - rd_ptr;
   assign full  = (used == (IW+1)'(OUTSTANDING));
   assign empty = (wr_ptr == rd_ptr);
   assign head  = mem[rd_idx];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         mem    <= '0;
      end else begin
         if (push && !full) begin
            mem[wr_idx] <= push_id;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one sram-like master port between the
// instruction-fetch and data (MEM) requesters.
// Handshake: a requester holds req and its fields stable until addr_ok;
// a request is accepted in any cycle with m_req & m_addr_ok, and each
// accepted request later receives exactly one m_data_ok, in order.
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   inst_* / data_*          requester request fields, addr_ok/data_ok/rdata
//   m_*                      shared master port
//   proto_err                sticky: m_data_ok seen with nothing outstanding
//   fsm_state                request-side FSM state (debug)
module sram_req_arbiter
   import sram_arb_pkg::*;
#(
   parameter int OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        m_req,
   output logic        m_wr,
   output logic [1:0]  m_size,
   output logic [3:0]  m_wstrb,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [31:0] m_rdata,
   output logic        proto_err,
   output arb_state_t  fsm_state
);

   arb_state_t state, state_next;
   logic grant_i, grant_d;
   logic accept, pop;
   logic fifo_head, fifo_full, fifo_empty;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Grant and next state. In a LOCK state the grant follows only the locked
   // requester; if it withdraws, m_req drops and the FSM falls back to IDLE.
   always_comb begin
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      state_next = ST_IDLE;
      unique case (state)
         ST_IDLE: begin
            if (!fifo_full) begin
               if (data_req)      grant_d = 1'b1;
               else if (inst_req) grant_i = 1'b1;
            end
         end
         ST_LOCK_I: grant_i = inst_req;
         ST_LOCK_D: grant_d = data_req;
         default: ;
      endcase
      if ((grant_i || grant_d) && !m_addr_ok) begin
         state_next = grant_d ? ST_LOCK_D : ST_LOCK_I;
      end
   end

   assign m_req   = grant_i | grant_d;
   assign accept  = m_req & m_addr_ok;
   assign m_wr    = (grant_d & data_wr) | (grant_i & inst_wr);
   assign m_size  = ({2{grant_d}} & data_size)   | ({2{grant_i}} & inst_size);
   assign m_wstrb = ({4{grant_d}} & data_wstrb)  | ({4{grant_i}} & inst_wstrb);
   assign m_addr  = ({32{grant_d}} & data_addr)  | ({32{grant_i}} & inst_addr);
   assign m_wdata = ({32{grant_d}} & data_wdata) | ({32{grant_i}} & inst_wdata);

   assign inst_addr_ok = grant_i & m_addr_ok;
   assign data_addr_ok = grant_d & m_addr_ok;

   sram_arb_id_fifo #(
      .OUTSTANDING(OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (accept),
      .push_id (grant_d ? ID_DATA : ID_INST),
      .pop     (pop),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Responses are routed by the oldest outstanding owner, with no latency.
   assign pop          = m_data_ok & ~fifo_empty;
   assign inst_data_ok = pop & (fifo_head == ID_INST);
   assign data_data_ok = pop & (fifo_head == ID_DATA);
   assign inst_rdata   = inst_data_ok ? m_rdata : 32'h0;
   assign data_rdata   = data_data_ok ? m_rdata : 32'h0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         proto_err <= 1'b0;
      end else if (m_data_ok && fifo_empty) begin
         proto_err <= 1'b1;
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Every expected
// addr_ok / data_ok event is queued as it is driven and popped by a
// monitor that runs alongside the driver.
module tb_sram_req_arbiter;
   import sram_arb_pkg::*;

   localparam logic [1:0] EV_IA = 2'd0;  // inst_addr_ok, value = m_addr
   localparam logic [1:0] EV_DA = 2'd1;  // data_addr_ok, value = m_addr
   localparam logic [1:0] EV_ID = 2'd2;  // inst_data_ok, value = inst_rdata
   localparam logic [1:0] EV_DD = 2'd3;  // data_data_ok, value = data_rdata

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [3:0]  inst_wstrb, data_wstrb;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        m_req, m_wr, m_addr_ok, m_data_ok;
   logic [1:0]  m_size;
   logic [3:0]  m_wstrb;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        proto_err;
   arb_state_t  fsm_state;

   logic [33:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sram_req_arbiter #(.OUTSTANDING(2)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
      .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .proto_err(proto_err), .fsm_state(fsm_state)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_evt(input logic [1:0] k, input logic [31:0] v);
      exp_q.push_back({k, v});
   endtask

   task automatic got_evt(input logic [1:0] k, input logic [31:0] v);
      logic [33:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL event: got kind %0d value 0x%08h, want no event", k, v);
      end else begin
         e = exp_q.pop_front();
         if (e !== {k, v}) begin
            n_err++;
            $display("FAIL event: got kind %0d value 0x%08h, want kind %0d value 0x%08h",
                     k, v, e[33:32], e[31:0]);
         end
      end
   endtask

   // Address events are compared before response events in the same cycle.
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (inst_addr_ok) got_evt(EV_IA, m_addr);
         if (data_addr_ok) got_evt(EV_DA, m_addr);
         if (inst_data_ok) got_evt(EV_ID, inst_rdata);
         if (data_data_ok) got_evt(EV_DD, data_rdata);
      end
   endtask

   initial begin
      resetn = 1'b0;
      inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = SZ_WORD; data_wstrb = 0; data_addr = 0; data_wdata = 0;
      m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
      fork
         monitor();
      join_none

      // Reset state
      step(); step();
      at_neg();
      chk("rst_m_req", m_req, 0);
      chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
      chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
      chk("rst_proto_err", proto_err, 0);
      chk("rst_state", fsm_state, ST_IDLE);
      step(); resetn = 1'b1;

      // Priority: data wins over inst, inst granted next cycle
      step();
      inst_req = 1; inst_addr = 32'h1c000040;
      data_req = 1; data_wr = 1; data_size = SZ_HALF; data_wstrb = 4'hf;
      data_addr = 32'h1c000100; data_wdata = 32'hdeadbeef;
      m_addr_ok = 1;
      expect_evt(EV_DA, 32'h1c000100);
      at_neg();
      chk("prio_m_req", m_req, 1);
      chk("prio_m_addr", m_addr, 32'h1c000100);
      chk("prio_m_wr", m_wr, 1);
      chk("prio_m_size", m_size, SZ_HALF);
      chk("prio_m_wstrb", m_wstrb, 4'hf);
      chk("prio_m_wdata", m_wdata, 32'hdeadbeef);
      step();
      data_req = 0; data_wr = 0; data_wstrb = 0; data_wdata = 0; data_size = SZ_WORD;
      expect_evt(EV_IA, 32'h1c000040);
      at_neg();
      chk("prio2_m_addr", m_addr, 32'h1c000040);
      chk("prio2_m_wr", m_wr, 0);
      step();
      inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h11110000;
      expect_evt(EV_DD, 32'h11110000);
      at_neg();
      chk("prio_resp_inst_rdata_idle", inst_rdata, 0);
      step();
      m_rdata = 32'h22220000;
      expect_evt(EV_ID, 32'h22220000);
      at_neg();
      chk("prio_resp_data_rdata_idle", data_rdata, 0);
      step();
      m_data_ok = 0; m_rdata = 0;

      // Lock: inst held without addr_ok; data arrives but must wait
      step();
      inst_req = 1; inst_addr = 32'h1c000000;
      at_neg();
      chk("lock_c0_m_addr", m_addr, 32'h1c000000);
      for (int c = 1; c <= 3; c++) begin
         step();
         if (c == 1) begin
            data_req = 1; data_addr = 32'h1c000200;
         end
         at_neg();
         chk("lock_m_addr", m_addr, 32'h1c000000);
         chk("lock_state", fsm_state, ST_LOCK_I);
      end
      step();
      m_addr_ok = 1;
      expect_evt(EV_IA, 32'h1c000000);
      at_neg();
      chk("lock_accept_data_addr_ok", data_addr_ok, 0);
      step();
      inst_req = 0;
      expect_evt(EV_DA, 32'h1c000200);
      at_neg();
      chk("lock_then_data_m_addr", m_addr, 32'h1c000200);

      // Routing in order: inst response first, then data
      step();
      data_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hAAAA5555;
      expect_evt(EV_ID, 32'hAAAA5555);
      at_neg();
      chk("route1_data_rdata", data_rdata, 0);
      step();
      m_rdata = 32'h12345678;
      expect_evt(EV_DD, 32'h12345678);
      at_neg();
      chk("route2_inst_rdata", inst_rdata, 0);
      step();
      m_data_ok = 0; m_rdata = 0;

      // Full: two outstanding block a third; a pop frees a slot only next cycle
      step();
      inst_req = 1; inst_addr = 32'h00000100; m_addr_ok = 1;
      expect_evt(EV_IA, 32'h00000100);
      step();
      inst_addr = 32'h00000104;
      expect_evt(EV_IA, 32'h00000104);
      step();
      inst_addr = 32'h00000108;
      at_neg();
      chk("full_m_req", m_req, 0);
      step();
      m_data_ok = 1; m_rdata = 32'h00000001;
      expect_evt(EV_ID, 32'h00000001);
      at_neg();
      chk("full_pop_same_cycle_m_req", m_req, 0);
      step();
      m_data_ok = 0;
      expect_evt(EV_IA, 32'h00000108);
      at_neg();
      chk("full_pop_next_cycle_m_req", m_req, 1);
      step();
      inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h00000002;
      expect_evt(EV_ID, 32'h00000002);
      step();
      m_rdata = 32'h00000003;
      expect_evt(EV_ID, 32'h00000003);
      step();
      m_data_ok = 0; m_rdata = 0;

      // Flush: locked data request withdrawn, nothing pushed
      step();
      data_req = 1; data_addr = 32'h1c000300;
      at_neg();
      chk("flush_m_req_lockcycle", m_req, 1);
      step();
      data_req = 0; inst_req = 1; inst_addr = 32'h1c000010;
      at_neg();
      chk("flush_m_req_drop", m_req, 0);
      chk("flush_state_lockd", fsm_state, ST_LOCK_D);
      step();
      m_addr_ok = 1;
      expect_evt(EV_IA, 32'h1c000010);
      at_neg();
      chk("flush_state_idle", fsm_state, ST_IDLE);
      chk("flush_inst_m_addr", m_addr, 32'h1c000010);
      // push and pop in the same cycle keep occupancy at 1
      step();
      inst_addr = 32'h1c000014; m_data_ok = 1; m_rdata = 32'h00000005;
      expect_evt(EV_IA, 32'h1c000014);
      expect_evt(EV_ID, 32'h00000005);
      step();
      m_data_ok = 0; m_rdata = 0; inst_addr = 32'h1c000018;
      expect_evt(EV_IA, 32'h1c000018);
      step();
      inst_addr = 32'h1c00001c;
      at_neg();
      chk("flush_occupancy_full_m_req", m_req, 0);
      step();
      inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h00000006;
      expect_evt(EV_ID, 32'h00000006);
      step();
      m_rdata = 32'h00000007;
      expect_evt(EV_ID, 32'h00000007);
      step();
      m_data_ok = 0; m_rdata = 0;

      // Reset mid-flight, then a late response is a stray
      step();
      inst_req = 1; inst_addr = 32'h00000040; m_addr_ok = 1;
      expect_evt(EV_IA, 32'h00000040);
      step();
      inst_req = 0; m_addr_ok = 0; resetn = 0;
      at_neg();
      chk("midrst_m_req", m_req, 0);
      chk("midrst_proto_err", proto_err, 0);
      step();
      resetn = 1;
      step();
      m_data_ok = 1; m_rdata = 32'h00000bad;
      at_neg();
      chk("stray_inst_data_ok", inst_data_ok, 0);
      chk("stray_data_data_ok", data_data_ok, 0);
      step();
      m_data_ok = 0; m_rdata = 0;
      at_neg();
      chk("stray_proto_err", proto_err, 1);
      step(); step(); step();
      at_neg();
      chk("stray_proto_err_sticky", proto_err, 1);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one sram-like master port (req/addr_ok/data_ok handshake) between the instruction-fetch requester and the data (MEM stage) requester.
- Applies fixed priority, data over inst, and holds a grant until the request is accepted.
- Records the owner of each accepted transaction in an in-order ID FIFO, so that each data_ok response is routed back to the requester that issued it.
- Sits between the fetch/MEM stages and the memory bridge.

Parameters:
- OUTSTANDING, 2, maximum number of accepted transactions still awaiting data_ok (power of two, >=1).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  in  1  instruction request valid.
- inst_wr  in  1  write flag; instruction side ties this to 0.
- inst_size  in  2  access size, 0=byte, 1=half, 2=word.
- inst_wstrb  in  4  byte write strobes.
- inst_addr  in  32  request address.
- inst_wdata  in  32  write data.
- inst_addr_ok  out  1  inst request accepted this cycle.
- inst_data_ok  out  1  inst response valid.
- inst_rdata  out  32  inst read data.
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  same meanings as the inst_* inputs, for the data requester.
- data_addr_ok, data_data_ok  out  1/1  same meanings as the inst_* outputs, for the data requester.
- data_rdata  out  32  data read data.
- m_req  out  1  master request.
- m_wr  out  1  master write flag.
- m_size  out  2  master access size.
- m_wstrb  out  4  master byte strobes.
- m_addr  out  32  master address.
- m_wdata  out  32  master write data.
- m_addr_ok  in  1  master accepted the request.
- m_data_ok  in  1  master response valid.
- m_rdata  in  32  master read data.
- proto_err  out  1  sticky flag: m_data_ok arrived with no transaction outstanding.

Behaviour:
- Reset: resetn low, asynchronously:
  - FSM goes to IDLE, FIFO empties, proto_err=0.
  - All outputs are 0: m_req, all addr_ok, all data_ok.
- Request-side FSM states:
  - IDLE: no grant held.
  - LOCK_I: grant held for inst; m_req was asserted without addr_ok.
  - LOCK_D: grant held for data; same condition.
- Grant selection:
  - In IDLE with FIFO not full: grant data if data_req=1, else inst if inst_req=1.
  - In IDLE with FIFO full: no grant, m_req=0.
  - In LOCK_x: grant stays on x regardless of the other request; the FIFO cannot be full here, because the slot was checked at grant.
- Master request outputs:
  - m_req = grant active.
  - m_wr/m_size/m_wstrb/m_addr/m_wdata are muxed combinationally from the granted requester.
  - When there is no grant, these fields drive 0.
- Acceptance:
  - Condition: m_req & m_addr_ok.
  - Raises the granted requester's addr_ok in the same cycle (combinational from m_addr_ok).
  - Pushes the owner ID (0=inst, 1=data) into the FIFO.
  - FSM returns to IDLE.
  - Back-to-back accepts on consecutive cycles are allowed.
- Hold without acceptance:
  - Condition: m_req=1 & m_addr_ok=0.
  - FSM goes to LOCK_I or LOCK_D.
  - Requesters hold their fields stable while req=1 and addr_ok=0; the arbiter does not check this.
- Withdrawn request while locked: if the locked requester drops req (flush), the FSM returns to IDLE next cycle, m_req=0 that cycle, nothing is pushed.
- Response routing:
  - m_data_ok with the FIFO non-empty pops the head.
  - If head=0: inst_data_ok=1, inst_rdata=m_rdata.
  - If head=1: data_data_ok=1, data_rdata=m_rdata.
  - Routing is combinational, zero latency. The non-selected rdata drives 0.
- Writes: also receive a data_ok and pop the FIFO like reads.
- Push and pop in the same cycle: allowed, occupancy unchanged. The full check uses the registered occupancy, so a simultaneous pop does not free a slot for that cycle's grant.
- Stray response: m_data_ok with the FIFO empty is ignored (no requester data_ok) and sets proto_err to 1 until reset.
- Pointer wrap-around: pointers are log2(OUTSTANDING) bits plus one wrap bit; full = equal index with differing wrap bit.
- Reset mid-transaction: all in-flight IDs are discarded; late m_data_ok after reset sets proto_err.

Decomposition:
- Shared package sram_arb_pkg:
  - Owner ID constants ID_INST=1'b0, ID_DATA=1'b1.
  - FSM state encodings for IDLE/LOCK_I/LOCK_D.
  - Size constants SZ_BYTE/SZ_HALF/SZ_WORD.
- One sub-module sram_arb_id_fifo:
  - Parameterised depth OUTSTANDING, 1-bit data.
  - Ports: push, pop, head, full, empty.
  - Async active-low reset.
- The top level holds the FSM, muxes and routing.

Test Plan:
- Priority: inst_req=1 and data_req=1 in the same cycle, m_addr_ok=1, data_addr=0x1c000100 -> m_addr=0x1c000100, data_addr_ok=1, inst_addr_ok=0. Next cycle inst is granted and inst_addr_ok=1.
- Lock: inst_req, inst_addr=0x1c000000, m_addr_ok=0 for 3 cycles, data_req rises at cycle 1 -> m_addr stays 0x1c000000 through cycle 3. Accept at cycle 4 -> inst_addr_ok=1. Data is granted at cycle 5.
- Routing/order: accept inst then data with OUTSTANDING=2, then m_data_ok with rdata 0xAAAA5555 then 0x12345678 -> inst_rdata=0xAAAA5555 on the first, data_rdata=0x12345678 on the second.
- Full: 2 accepted with no response -> m_req=0 with a request pending. A single m_data_ok pops -> m_req reasserts the next cycle, not the same cycle.
- Stray/reset: assert resetn=0 mid-flight with 1 outstanding, release, pulse m_data_ok -> no requester data_ok, proto_err=1 and it stays 1.
- Flush: data locked, data_req drops -> m_req=0 next cycle, FIFO occupancy unchanged, inst granted the following cycle.
